// File: rtl/lfsr_range_rng.sv
// ============================================================================
// lfsr_range_rng
// ----------------------------------------------------------------------------
// Purpose:
//   Fibonacci-LFSR random number generator that emits samples uniformly spread
//   over [OFFSET, OFFSET+RANGE-1]. Samples leave through a one-entry
//   valid/ready output register. Candidates of RW = max(1, clog2(RANGE)) low
//   LFSR bits that are >= RANGE are rejected rather than folded, so ranges that
//   are not a power of two stay unbiased.
//
//   The LFSR advances only on a load-condition cycle:
//   enable=1 and the output slot is empty or being consumed.
//   Because of this, the emitted sequence does not depend on backpressure or
//   on enable gaps.
//
// Optional feature (macro RNG_LOCKUP_RECOVER_EN):
//   When defined, an all-zero LFSR is reloaded with SEED on the next edge and
//   lockup_flag pulses for one cycle. When undefined, a zero LFSR stays at zero
//   and lockup_flag is tied low.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high
//   enable       in   permits LFSR advance and sample capture
//   seed_load    in   one-cycle reload request (priority over everything else
//                     except reset)
//   seed_in      in   [WIDTH]  reload value; zero selects SEED instead
//   rand_ready   in   consumer accepts rand_value
//   rand_valid   out  rand_value holds an unconsumed sample
//   rand_value   out  [OUT_W]  OFFSET + accepted candidate
//   lockup_flag  out  one-cycle pulse on lockup recovery
// ============================================================================
module lfsr_range_rng #(
    parameter int WIDTH  = 10,
    parameter int SEED   = 340,
    parameter int OFFSET = 200,
    parameter int RANGE  = 16,
    parameter int OUT_W  = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             rand_ready,
    output logic             rand_valid,
    output logic [OUT_W-1:0] rand_value,
    output logic             lockup_flag
);

    // Tap masks. Tap t (1-based bit numbering) maps to vector bit t-1.
    function automatic logic [15:0] tap_mask(input int w);
        logic [15:0] m;
        case (w)
            4:       m = 16'h000C; // 4,3
            5:       m = 16'h0014; // 5,3
            6:       m = 16'h0030; // 6,5
            7:       m = 16'h0060; // 7,6
            8:       m = 16'h00B8; // 8,6,5,4
            9:       m = 16'h0110; // 9,5
            10:      m = 16'h0240; // 10,7
            11:      m = 16'h0500; // 11,9
            12:      m = 16'h0E08; // 12,11,10,4
            13:      m = 16'h1C80; // 13,12,11,8
            14:      m = 16'h3802; // 14,13,12,2
            15:      m = 16'h6000; // 15,14
            16:      m = 16'hD008; // 16,15,13,4
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

    localparam int RW = (RANGE <= 2) ? 1 : $clog2(RANGE);
    localparam logic [15:0]      TAP_ALL  = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0] TAPS     = TAP_ALL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SEED_W   = WIDTH'(SEED);
    localparam logic [RW:0]      RANGE_W  = (RW+1)'(RANGE);
    localparam logic [OUT_W-1:0] OFFSET_W = OUT_W'(OFFSET);

    // Parameter legality is checked at elaboration time.
    generate
        if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
            $error("lfsr_range_rng: WIDTH must be in 4..16");
        end
        if (SEED <= 0 || SEED >= (1 << WIDTH)) begin : g_bad_seed
            $error("lfsr_range_rng: SEED must be non-zero and below 2^WIDTH");
        end
        if (RANGE < 1 || RANGE > (1 << (WIDTH - 1))) begin : g_bad_range
            $error("lfsr_range_rng: RANGE must be in 1..2^(WIDTH-1)");
        end
        if ((OFFSET + RANGE - 1) >= (1 << OUT_W)) begin : g_bad_outw
            $error("lfsr_range_rng: OUT_W too narrow for OFFSET+RANGE-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        FULL   = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] lfsr_reg, lfsr_next;
    logic [OUT_W-1:0] value_reg, value_next;

    // Feedback: XOR of the tapped bits.
    logic [WIDTH-1:0] tapped;
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_tap
            assign tapped[gi] = lfsr_reg[gi] & TAPS[gi];
        end
    endgenerate

    logic          fb;
    logic [RW-1:0] candidate;
    logic          accept;
    logic          valid;
    logic          load;

    assign fb        = ^tapped;
    assign candidate = lfsr_reg[RW-1:0];
    assign accept    = ({1'b0, candidate} < RANGE_W);
    assign valid     = (state_reg == FULL);
    assign load      = enable && (!valid || rand_ready);

`ifdef RNG_LOCKUP_RECOVER_EN
    logic lockup_flag_reg, lockup_flag_next;
`endif

    always_comb begin
        state_next = state_reg;
        lfsr_next  = lfsr_reg;
        value_next = value_reg;
`ifdef RNG_LOCKUP_RECOVER_EN
        lockup_flag_next = 1'b0;
`endif
        if (seed_load) begin
            // A handshake coinciding with the reload still counts as a transfer.
            lfsr_next  = (seed_in == '0) ? SEED_W : seed_in;
            state_next = enable ? SEARCH : IDLE;
        end
`ifdef RNG_LOCKUP_RECOVER_EN
        else if (lfsr_reg == '0) begin
            // No sample is drawn from the zero state; the held sample keeps
            // its normal handshake behaviour.
            lfsr_next        = SEED_W;
            lockup_flag_next = 1'b1;
            if (!valid || rand_ready) begin
                state_next = enable ? SEARCH : IDLE;
            end
        end
`endif
        else if (load) begin
            lfsr_next = {lfsr_reg[WIDTH-2:0], fb};
            if (accept) begin
                value_next = OFFSET_W + OUT_W'(candidate);
                state_next = FULL;
            end else begin
                state_next = SEARCH;
            end
        end else if (!enable) begin
            // A held sample may still drain while disabled.
            if (!valid || rand_ready) begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            lfsr_reg  <= SEED_W;
            value_reg <= '0;
        end else begin
            state_reg <= state_next;
            lfsr_reg  <= lfsr_next;
            value_reg <= value_next;
        end
    end

`ifdef RNG_LOCKUP_RECOVER_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            lockup_flag_reg <= 1'b0;
        end else begin
            lockup_flag_reg <= lockup_flag_next;
        end
    end
    assign lockup_flag = lockup_flag_reg;
`else
    assign lockup_flag = 1'b0;
`endif

    assign rand_valid = valid;
    assign rand_value = value_reg;

endmodule

// File: tb/tb_lfsr_range_rng.sv
// ============================================================================
// tb_lfsr_range_rng
// ----------------------------------------------------------------------------
// Directed, table-driven bench. One instance uses the default parameters,
// a second uses RANGE=5 to exercise rejection gaps. Expected values are
// hand-derived from the LFSR recurrence (taps 10,7):
//   340 -> 681 -> 339 -> 679 -> 335 -> 671 -> 319 -> 638 -> 252
//   low-4 candidates: 4, 9, 3, 7, 15 ...   low-3 candidates: 4, 1, 3, 7, 7,
//   7, 7, 6, 4
// ============================================================================
module tb_lfsr_range_rng;

    logic        clk = 1'b0;
    logic        reset, enable, seed_load, rand_ready;
    logic [9:0]  seed_in;
    logic        rand_valid, lockup_flag;
    logic [10:0] rand_value;

    logic        reset5, enable5, seed_load5, rand_ready5;
    logic [9:0]  seed_in5;
    logic        rand_valid5, lockup_flag5;
    logic [10:0] rand_value5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lfsr_range_rng dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .seed_load   (seed_load),
        .seed_in     (seed_in),
        .rand_ready  (rand_ready),
        .rand_valid  (rand_valid),
        .rand_value  (rand_value),
        .lockup_flag (lockup_flag)
    );

    lfsr_range_rng #(.RANGE(5)) dut5 (
        .clk         (clk),
        .reset       (reset5),
        .enable      (enable5),
        .seed_load   (seed_load5),
        .seed_in     (seed_in5),
        .rand_ready  (rand_ready5),
        .rand_valid  (rand_valid5),
        .rand_value  (rand_value5),
        .lockup_flag (lockup_flag5)
    );

    typedef struct packed {
        logic        rst;
        logic        en;
        logic        rdy;
        logic        sl;
        logic [9:0]  sin;
        logic        ev;
        logic [10:0] evalue;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic en, input logic rdy,
                       input logic sl, input logic [9:0] sin,
                       input logic ev, input logic [10:0] evalue);
        vec_t v;
        v.rst = rst; v.en = en; v.rdy = rdy; v.sl = sl; v.sin = sin;
        v.ev = ev; v.evalue = evalue;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int exp5_valid[9] = '{1, 1, 1, 0, 0, 0, 0, 0, 1};
    int exp5_value[9] = '{204, 201, 203, 0, 0, 0, 0, 0, 204};

    initial begin
        reset = 1'b1; enable = 1'b0; seed_load = 1'b0; seed_in = '0;
        rand_ready = 1'b0;
        reset5 = 1'b1; enable5 = 1'b0; seed_load5 = 1'b0; seed_in5 = '0;
        rand_ready5 = 1'b1;

        step();
        step();
        chk("reset valid", rand_valid, 0);
        chk("reset value", rand_value, 0);
        chk("reset lockup_flag", lockup_flag, 0);

        reset = 1'b0;
        step();
        chk("idle valid", rand_valid, 0);

        //   rst  en   rdy  sl   seed  ev   value
        add(0, 1, 1, 0, 10'd0,   1, 11'd204); // first enable -> valid next cycle
        add(0, 1, 1, 0, 10'd0,   1, 11'd209);
        add(0, 1, 1, 0, 10'd0,   1, 11'd203);
        for (int i = 0; i < 5; i++)
            add(0, 1, 0, 0, 10'd0, 1, 11'd203); // backpressure holds
        add(0, 1, 1, 0, 10'd0,   1, 11'd207); // sequence resumes unchanged
        add(0, 0, 0, 0, 10'd0,   1, 11'd207); // disabled, not consumed
        add(0, 0, 1, 0, 10'd0,   0, 11'd0);   // disabled, drained
        add(0, 0, 1, 0, 10'd0,   0, 11'd0);
        add(0, 1, 1, 0, 10'd0,   1, 11'd215); // enable gap did not skip
        add(0, 1, 1, 1, 10'd0,   0, 11'd0);   // seed_in=0 -> SEED
        add(0, 1, 1, 0, 10'd0,   1, 11'd204);
        add(0, 1, 1, 0, 10'd0,   1, 11'd209);
        add(0, 1, 1, 1, 10'd681, 0, 11'd0);   // explicit seed
        add(0, 1, 1, 0, 10'd0,   1, 11'd209);
        add(0, 1, 1, 0, 10'd0,   1, 11'd203);
        add(0, 0, 1, 1, 10'd5,   0, 11'd0);   // reload while disabled
        add(0, 1, 1, 0, 10'd0,   1, 11'd205);
        add(0, 1, 1, 0, 10'd0,   1, 11'd210);
        add(0, 1, 0, 0, 10'd0,   1, 11'd210); // hold
        add(1, 1, 0, 0, 10'd0,   0, 11'd0);   // reset while FULL
        add(0, 1, 1, 0, 10'd0,   1, 11'd204);
        add(0, 1, 1, 0, 10'd0,   1, 11'd209);

        foreach (vecs[i]) begin
            reset      = vecs[i].rst;
            enable     = vecs[i].en;
            rand_ready = vecs[i].rdy;
            seed_load  = vecs[i].sl;
            seed_in    = vecs[i].sin;
            step();
            chk($sformatf("vec%0d valid", i), rand_valid, vecs[i].ev);
            if (vecs[i].ev || vecs[i].rst)
                chk($sformatf("vec%0d value", i), rand_value, vecs[i].evalue);
            chk($sformatf("vec%0d lockup_flag", i), lockup_flag, 0);
        end

        // Lockup: zero the LFSR while streaming.
        reset = 1'b0; enable = 1'b1; rand_ready = 1'b1; seed_load = 1'b0;
        force dut.lfsr_reg = '0;
        #1;
        release dut.lfsr_reg;
`ifdef RNG_LOCKUP_RECOVER_EN
        step();
        chk("lockup flag pulse", lockup_flag, 1);
        chk("lockup no sample", rand_valid, 0);
        step();
        chk("lockup flag clear", lockup_flag, 0);
        chk("lockup restart valid", rand_valid, 1);
        chk("lockup restart value", rand_value, 204);
        step();
        chk("lockup second value", rand_value, 209);
`else
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stuck%0d valid", i), rand_valid, 1);
            chk($sformatf("stuck%0d value", i), rand_value, 200);
            chk($sformatf("stuck%0d lockup_flag", i), lockup_flag, 0);
        end
`endif

        // RANGE=5: candidates 7,7,7,7,6 are rejected, producing a valid gap.
        reset5 = 1'b0; enable5 = 1'b1; rand_ready5 = 1'b1;
        chk("r5 pre valid", rand_valid5, 0);
        for (int i = 0; i < 9; i++) begin
            step();
            chk($sformatf("r5 step%0d valid", i), rand_valid5, exp5_valid[i]);
            if (exp5_valid[i] == 1)
                chk($sformatf("r5 step%0d value", i), rand_value5, exp5_value[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
